mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 11 +
 rtl/mem_arbiter_arb_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the N-port memory arbiter.
// Round-robin selection is enabled with MEM_ARBITER_RR_EN.
package mem_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} mem_arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection for mem_arbiter.
// MEM_ARBITER_RR_EN: round-robin from last+1, else lowest index wins.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int PW     = 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     last,
    output logic              valid,
    output logic [PW-1:0]     winner
);

`ifdef MEM_ARBITER_RR_EN
    logic found;
    int   idx;

    always_comb begin
        valid  = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = (int'(last) + 1 + i) % NPORTS;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    // Descending scan so the lowest requesting index is written last.
    always_comb begin
        valid  = |req;
        winner = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = PW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// N-port valid/ready memory arbiter with registered grant.
// MEM_ARBITER_RR_EN selects round-robin; default is fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            m_valid,
    input  logic [NPORTS-1:0]            m_instr,
    input  logic [NPORTS-1:0][AW-1:0]    m_addr,
    input  logic [NPORTS-1:0][DW-1:0]    m_wdata,
    input  logic [NPORTS-1:0][DW/8-1:0]  m_wstrb,
    output logic [NPORTS-1:0][DW-1:0]    m_rdata,
    output logic [NPORTS-1:0]            m_ready,
    output logic                         mem_valid,
    output logic                         mem_instr,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wdata,
    output logic [DW/8-1:0]              mem_wstrb,
    input  logic [DW-1:0]                mem_rdata,
    input  logic                         mem_ready
);

    localparam int PW = ptr_width(NPORTS);
    localparam int SW = DW / 8;

    typedef struct packed {
        mem_arb_state_t state;
        logic [PW-1:0]  grant;
        logic [PW-1:0]  last;
        logic           instr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [SW-1:0]  wstrb;
    } arb_reg_t;

    arb_reg_t      r_q;
    arb_reg_t      r_d;
    logic          pick_valid;
    logic [PW-1:0] pick_winner;

    arb_pick #(
        .NPORTS (NPORTS),
        .PW     (PW)
    ) u_pick (
        .req    (m_valid),
        .last   (r_q.last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_q.state <= ARB_IDLE;
            r_q.last  <= PW'(NPORTS - 1);
        end else begin
            r_q <= r_d;
        end
    end

    always_comb begin
        r_d = r_q;
        unique case (r_q.state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    r_d.state = ARB_BUSY;
                    r_d.grant = pick_winner;
                    r_d.instr = m_instr[pick_winner];
                    r_d.addr  = m_addr[pick_winner];
                    r_d.wdata = m_wdata[pick_winner];
                    r_d.wstrb = m_wstrb[pick_winner];
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    r_d.state = ARB_IDLE;
                    r_d.last  = r_q.grant;
                end
            end
            default: r_d = r_q;
        endcase
    end

    // Completion is suppressed during reset so an abandoned access never answers.
    always_comb begin
        m_ready = '0;
        m_rdata = '0;
        if (r_q.state == ARB_BUSY && mem_ready && !rst) begin
            m_ready[r_q.grant] = 1'b1;
            m_rdata[r_q.grant] = mem_rdata;
        end
    end

    assign mem_valid = (r_q.state == ARB_BUSY);
    assign mem_instr = r_q.instr;
    assign mem_addr  = r_q.addr;
    assign mem_wdata = r_q.wdata;
    assign mem_wstrb = r_q.wstrb;

endmodule
